// File: rtl/hamming_pkg.sv
// Shared SECDED types and helpers for the serial encoder (and the future decoder).
package hamming_pkg;

  typedef enum logic {LOAD, EMIT} state_t;

  localparam int R_MIN = 3;
  localparam int R_MAX = 6;

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int frame_len(input int r);
    return 1 << r;
  endfunction

  function automatic int data_len(input int r);
    return (1 << r) - r - 1;
  endfunction

  // Frame position of the idx-th data bit: idx-th non-power-of-two position >= 3.
  function automatic int data_pos(input int r, input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 3; p < (1 << r); p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_parity_acc.sv
// Syndrome / overall-parity accumulator; parity output already includes this cycle's bit.
module hamming_parity_acc
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dbit,
  input  logic [R-1:0] pos,
  output logic [R:0]   parity
);

  logic [R-1:0] syn_q, syn_d;
  logic         par_q, par_d;

  always_comb begin
    syn_d = syn_q;
    par_d = par_q;
    if (en && dbit) begin
      syn_d = syn_q ^ pos;
      par_d = ~par_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (clr) begin
      syn_q <= '0;
      par_q <= 1'b0;
    end else begin
      syn_q <= syn_d;
      par_q <= par_d;
    end
  end

  // {running data parity, syndrome}, post-update
  assign parity = {par_d, syn_d};

endmodule

// File: rtl/hamming_secded_serial_enc.sv
// Serial SECDED encoder: K data bits in, N=2**R frame bits out, position 0 first.
// Optional ENC_ERR_INJECT_EN adds err_inj/err_pos to flip one bit of a frame.
module hamming_secded_serial_enc
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_sof,
  output logic         dout_eof
`ifdef ENC_ERR_INJECT_EN
  ,
  input  logic         err_inj,
  input  logic [R-1:0] err_pos
`endif
);

  localparam int N  = frame_len(R);
  localparam int K  = data_len(R);
  localparam int IW = $clog2(K + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [R-1:0]  pos_q, pos_nx;
  logic [N-1:0]  frame_q, frame_d;
  logic [R:0]    parity;
  logic [R-1:0]  dpos;
  logic          acc_en, last_in, out_hs, last_out;

  // Data-index -> frame-position lookup, resolved at elaboration.
  logic [R-1:0] dpos_tab [2**IW];
  for (genvar i = 0; i < 2**IW; i++) begin : g_dpos
    if (i < K) begin : g_used
      assign dpos_tab[i] = R'(data_pos(R, i));
    end else begin : g_unused
      assign dpos_tab[i] = '0;
    end
  end
  assign dpos = dpos_tab[idx_q];

  assign din_ready = (state_q == LOAD) && !rst;
  assign pos_nx    = pos_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    acc_en   = 1'b0;
    last_in  = 1'b0;
    out_hs   = 1'b0;
    last_out = 1'b0;
    case (state_q)
      LOAD: begin
        acc_en = din_valid && din_ready;
        if (acc_en && idx_q == IW'(K - 1)) begin
          last_in = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_hs = dout_valid && dout_ready;
        if (out_hs && pos_q == R'(N - 1)) begin
          last_out = 1'b1;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  hamming_parity_acc #(.R(R)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (last_out),
    .en     (acc_en),
    .dbit   (din),
    .pos    (dpos),
    .parity (parity)
  );

  // Parity slots are written on the last accept using the post-update accumulators.
  always_comb begin
    frame_d = frame_q;
    if (acc_en) frame_d[dpos] = din;
    if (last_in) begin
      frame_d[0] = parity[R] ^ (^parity[R-1:0]);
      for (int i = 0; i < R; i++) frame_d[R'(1 << i)] = parity[i];
`ifdef ENC_ERR_INJECT_EN
      if (err_inj) frame_d[err_pos] = ~frame_d[err_pos];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      frame_q <= frame_d;
      if (last_out)                           idx_q <= '0;
      else if (acc_en && idx_q != IW'(K))     idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
    end else if (last_in) begin
      pos_q      <= '0;
      dout       <= frame_d[0];
      dout_valid <= 1'b1;
      dout_sof   <= 1'b1;
      dout_eof   <= 1'b0;
    end else if (out_hs) begin
      pos_q <= pos_nx;
      if (last_out) begin
        dout       <= 1'b0;
        dout_valid <= 1'b0;
        dout_sof   <= 1'b0;
        dout_eof   <= 1'b0;
      end else begin
        dout     <= frame_q[pos_nx];
        dout_sof <= 1'b0;
        dout_eof <= (pos_nx == R'(N - 1));
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_serial_enc.sv
// Scoreboard bench for hamming_secded_serial_enc at R=4 (16-bit frames, 11 data bits).
module tb_hamming_secded_serial_enc;

  localparam int R = 4;
  localparam int N = 16;
  localparam int K = 11;

  logic clk = 1'b0;
  logic rst, din, din_valid, din_ready;
  logic dout, dout_valid, dout_ready, dout_sof, dout_eof;
`ifdef ENC_ERR_INJECT_EN
  logic         err_inj;
  logic [R-1:0] err_pos;
`endif

  int total = 0;
  int bad   = 0;
  int fpos  = 0;
  logic [2:0] expq [$];

  always #5 clk = ~clk;

  hamming_secded_serial_enc #(.R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof)
`ifdef ENC_ERR_INJECT_EN
    ,
    .err_inj    (err_inj),
    .err_pos    (err_pos)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {dout,sof,eof} per accepted output bit.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      fpos = 0;
    end else if (dout_valid) begin
      chk("din_ready_in_emit", din_ready, 0);
      if (dout_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_output: got %b expected none", {dout, dout_sof, dout_eof});
        end else begin
          e = expq.pop_front();
          chk($sformatf("frame_pos%0d", fpos), {dout, dout_sof, dout_eof}, e);
          fpos = dout_eof ? 0 : fpos + 1;
        end
      end
    end
  end

  task automatic push_frame(input logic [N-1:0] f);
    for (int i = 0; i < N; i++) expq.push_back({f[i], (i == 0), (i == N - 1)});
  endtask

  task automatic send(input logic [K-1:0] data, input logic [N-1:0] f, input bit gaps, input bit hold);
    int n;
    push_frame(f);
    for (int i = 0; i < K; i++) begin
      din       = data[i];
      din_valid = 1'b1;
      n = 0;
      while (!din_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 50) chk("din_ready_timeout", din_ready, 1);
      @(posedge clk); #1;
      if (gaps && i < K - 1) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (hold) din = 1'b1;
    else      din_valid = 1'b0;
    chk("first_out_latency", {dout_valid, dout_sof}, 2'b11);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    din_valid = 1'b0;
    chk("drain", expq.size(), 0);
    chk("ready_after_eof", {din_ready, dout_valid}, 2'b10);
  endtask

  task automatic wait_fpos(input int p);
    int n;
    n = 0;
    while (fpos != p && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_fpos", fpos, p);
  endtask

  initial begin
    logic [2:0] held;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
`ifdef ENC_ERR_INJECT_EN
    err_inj = 1'b0; err_pos = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {dout, dout_valid, dout_sof, dout_eof}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_din_ready", din_ready, 1);
    @(posedge clk); #1;

    send(11'h000, 16'h0000, 1'b0, 1'b0); drain();   // all zero
    send(11'h001, 16'h000F, 1'b0, 1'b0); drain();   // first data bit -> pos 3
    send(11'h7FF, 16'hFFFF, 1'b1, 1'b0); drain();   // all ones, din_valid gaps
    send(11'h002, 16'h0033, 1'b0, 1'b0); drain();   // pos 5
    send(11'h400, 16'h8117, 1'b0, 1'b1); drain();   // pos 15, din_valid held during EMIT
    send(11'h000, 16'h0000, 1'b0, 1'b0); drain();   // nothing leaked from EMIT

    // Backpressure at pos 7
    send(11'h7FF, 16'hFFFF, 1'b0, 1'b0);
    wait_fpos(7);
    dout_ready = 1'b0;
    held = {dout, dout_sof, dout_eof};
    chk("stall_pos7", held, 3'b100);
    repeat (3) begin
      @(negedge clk);
      chk("stall_stable", {dout_valid, dout, dout_sof, dout_eof}, {1'b1, held});
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    drain();

    // Reset in the middle of EMIT
    send(11'h7FF, 16'hFFFF, 1'b0, 1'b0);
    wait_fpos(9);
    rst = 1'b1;
    #1;
    chk("rst_midframe", {dout_valid, dout, dout_sof, dout_eof}, 4'b0000);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_recover", {din_ready, dout_valid}, 2'b10);
    @(posedge clk); #1;
    send(11'h000, 16'h0000, 1'b0, 1'b0); drain();

`ifdef ENC_ERR_INJECT_EN
    err_inj = 1'b1; err_pos = 4'd5;
    send(11'h000, 16'h0020, 1'b0, 1'b0);
    err_inj = 1'b0;
    drain();
    send(11'h000, 16'h0000, 1'b0, 1'b0); drain();
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
